qam_symbol_mapper: RTL

Consumes the prescaled symbol-rate enable produced by the main counter and converts a buffered stream of data words into square-QAM I/Q amplitude symbols, one symbol per rising edge of the enable. It sits between the bit source (upstream handshake) and the I/Q shaping/DAC path (downstream). The block absorbs producer jitter in a small FIFO and reports underruns.

---
 rtl/qam_pkg.sv | 44 ++++
 rtl/qam_sync_fifo.sv | 58 +++++
 rtl/qam_symbol_mapper.sv | 128 ++++++++++++
 3 files changed

// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol mapper: Gray-to-level mapping,
// legal BITS_PER_SYM check and the zero-symbol constant.
package qam_pkg;

  // Widest axis supported: BITS_PER_SYM = 8 gives 4 bits per axis.
  localparam int MAX_AXIS_BITS = 4;
  localparam int LEVEL_W       = MAX_AXIS_BITS + 1;

  // Smallest and largest symbol widths the mapper supports.
  localparam int MIN_BITS_PER_SYM = 2;
  localparam int MAX_BITS_PER_SYM = 8;

  // Amplitude driven on underrun and out of reset.
  localparam logic signed [LEVEL_W-1:0] ZERO_LEVEL = '0;

  // Symbol width must be even and inside the supported range.
  function automatic bit bits_per_sym_legal(input int bps);
    return (bps >= MIN_BITS_PER_SYM) && (bps <= MAX_BITS_PER_SYM) && (bps % 2 == 0);
  endfunction

  // Gray-decode the low k bits of g to index n, then centre it:
  // level = 2n - (2^k - 1). Result fits in k+1 signed bits.
  function automatic logic signed [LEVEL_W-1:0] gray_to_level(
    input logic [MAX_AXIS_BITS-1:0] g,
    input int                       k
  );
    logic [MAX_AXIS_BITS-1:0] n;
    logic                     b;
    int                       nv;
    int                       lvl;
    n = '0;
    b = 1'b0;
    for (int i = MAX_AXIS_BITS - 1; i >= 0; i--) begin
      if (i < k) begin
        b    = b ^ g[i];
        n[i] = b;
      end
    end
    nv  = int'(n);
    lvl = 2 * nv - ((1 << k) - 1);
    return lvl[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/qam_sync_fifo.sv
// Single-clock FIFO buffering data words ahead of the symbol mapper.
// Writes when full and reads when empty are ignored. Storage is not reset;
// pointers and occupancy are.
module qam_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; DEPTH is a power of two so pointer overflow wraps.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qam_symbol_mapper.sv
// Square-QAM symbol mapper: buffers data words, and on each rising edge of
// en_clk pops one word and registers its Gray-coded I/Q amplitudes.
// Optional feature macro: QAM_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun event counter output (underrun_cnt).
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_clk,
  input  logic [BITS_PER_SYM-1:0]       din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic signed [BITS_PER_SYM/2:0] i_out,
  output logic signed [BITS_PER_SYM/2:0] q_out,
  output logic                          sym_valid,
  output logic                          underrun
`ifdef QAM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam int K      = BITS_PER_SYM / 2;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam bit BPS_OK = bits_per_sym_legal(BITS_PER_SYM);
  localparam logic signed [K:0] ZERO_SYM = ZERO_LEVEL[K:0];

  logic                    en_d;
  logic                    strobe_p0;
  logic                    push_p0;
  logic                    pop_p0;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [BITS_PER_SYM-1:0] word_p0;
  logic [MAX_AXIS_BITS-1:0] g_i_p0;
  logic [MAX_AXIS_BITS-1:0] g_q_p0;
  logic signed [LEVEL_W-1:0] lvl_i_p0;
  logic signed [LEVEL_W-1:0] lvl_q_p0;
  logic signed [K:0]       i_nxt_p0;
  logic signed [K:0]       q_nxt_p0;
  logic signed [K:0]       i_p1;
  logic signed [K:0]       q_p1;
  logic                    vld_p1;
  logic                    underrun_q;

  assign strobe_p0 = en_clk & ~en_d;
  assign push_p0   = din_valid & ~fifo_full;
  assign pop_p0    = strobe_p0 & ~fifo_empty;
  assign din_ready = (fifo_count != CW'(FIFO_DEPTH));

  qam_sync_fifo #(
    .WIDTH (BITS_PER_SYM),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_p0),
    .wdata (din),
    .pop   (pop_p0),
    .rdata (word_p0),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage p0: split the head word into I/Q Gray codes and map to amplitudes.
  always_comb begin
    g_i_p0          = '0;
    g_q_p0          = '0;
    g_i_p0[K-1:0]   = word_p0[BITS_PER_SYM-1:K];
    g_q_p0[K-1:0]   = word_p0[K-1:0];
    lvl_i_p0        = gray_to_level(g_i_p0, K);
    lvl_q_p0        = gray_to_level(g_q_p0, K);
    if (BPS_OK) begin
      i_nxt_p0 = lvl_i_p0[K:0];
      q_nxt_p0 = lvl_q_p0[K:0];
    end else begin
      i_nxt_p0 = ZERO_SYM;
      q_nxt_p0 = ZERO_SYM;
    end
  end

  // Stage p1: edge-detect en_clk and register the symbol (zero on underrun).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d       <= 1'b0;
      vld_p1     <= 1'b0;
      i_p1       <= ZERO_SYM;
      q_p1       <= ZERO_SYM;
      underrun_q <= 1'b0;
    end else begin
      en_d   <= en_clk;
      vld_p1 <= strobe_p0;
      if (strobe_p0) begin
        if (!fifo_empty) begin
          i_p1 <= i_nxt_p0;
          q_p1 <= q_nxt_p0;
        end else begin
          i_p1       <= ZERO_SYM;
          q_p1       <= ZERO_SYM;
          underrun_q <= 1'b1;
        end
      end
    end
  end

`ifdef QAM_UNDERRUN_CNT_EN
  // Count underrun strobes, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_cnt <= '0;
    end else if (strobe_p0 && fifo_empty && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

  assign i_out     = i_p1;
  assign q_out     = q_p1;
  assign sym_valid = vld_p1;
  assign underrun  = underrun_q;

endmodule
